// File: rtl/mac_accum_requant_if.sv
// Handshake bundle between the MAC-result accumulator and its producer/consumer.
// The master side drives the command and the MAC results. The slave side returns the requantized result.
interface mac_accum_requant_if #(
    parameter int IN_BITWIDTH  = 16,
    parameter int OUT_BITWIDTH = 8,
    parameter int LEN_BITWIDTH = 8
);
    logic                    START;
    logic [LEN_BITWIDTH-1:0] LEN;
    logic                    IN_VALID;
    logic [IN_BITWIDTH-1:0]  IN_DATA;
    logic                    OUT_READY;
    logic                    OUT_VALID;
    logic [OUT_BITWIDTH-1:0] OUT_DATA;
    logic                    SAT;
    logic                    BUSY;

    modport master (
        output START, LEN, IN_VALID, IN_DATA, OUT_READY,
        input  OUT_VALID, OUT_DATA, SAT, BUSY
    );

    modport slave (
        input  START, LEN, IN_VALID, IN_DATA, OUT_READY,
        output OUT_VALID, OUT_DATA, SAT, BUSY
    );
endinterface

// File: rtl/mac_accum_requant.sv
// Sums LEN Q3.12 MAC results into a wide accumulator, then rounds and saturates the sum to Q1.6 behind a valid/ready port.
// Optional build macro MAC_ACCUM_REQUANT_RELU_EN clamps negative results to zero. That clamp does not set SAT.
module mac_accum_requant #(
    parameter int IN_BITWIDTH  = 16,
    parameter int OUT_BITWIDTH = 8,
    parameter int FRAC_SHIFT   = 6,
    parameter int LEN_BITWIDTH = 8,
    parameter int ACC_BITWIDTH = 24
) (
    input  logic              CLK,
    input  logic              RST,
    mac_accum_requant_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_ROUND = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // One guard bit above the accumulator keeps the rounding bias from wrapping.
    typedef logic signed [ACC_BITWIDTH:0] wide_t;

    localparam wide_t ROUND_BIAS = wide_t'(2 ** (FRAC_SHIFT - 1));
    localparam wide_t OUT_MAX    = wide_t'(2 ** (OUT_BITWIDTH - 1) - 1);
    localparam wide_t OUT_MIN    = -(wide_t'(2 ** (OUT_BITWIDTH - 1)));
    localparam wide_t WIDE_ZERO  = wide_t'(0);

    state_t                   state_r;
    state_t                   state_s;
    logic [ACC_BITWIDTH-1:0]  acc_r;
    logic [LEN_BITWIDTH-1:0]  count_r;
    logic [LEN_BITWIDTH-1:0]  len_r;
    logic                     out_valid_r;
    logic                     out_valid_s;
    logic [OUT_BITWIDTH-1:0]  out_data_r;
    logic [OUT_BITWIDTH-1:0]  out_data_s;
    logic                     sat_r;
    logic                     sat_s;
    logic                     busy_r;
    logic                     busy_s;
    logic [ACC_BITWIDTH-1:0]  in_ext_s;
    logic                     last_in_s;

    // Round half toward +inf with an arithmetic shift, then clip. The return value is {sat, data}.
    function automatic logic [OUT_BITWIDTH:0] requant(input logic [ACC_BITWIDTH-1:0] acc);
        wide_t biased;
        wide_t r;
        logic [OUT_BITWIDTH:0] res;
        biased = $signed({acc[ACC_BITWIDTH-1], acc}) + ROUND_BIAS;
        r      = biased >>> FRAC_SHIFT;
        if (r > OUT_MAX) begin
            res = {1'b1, OUT_MAX[OUT_BITWIDTH-1:0]};
        end
`ifdef MAC_ACCUM_REQUANT_RELU_EN
        else if (r < WIDE_ZERO) begin
            res = {1'b0, {OUT_BITWIDTH{1'b0}}};
        end
`endif
        else if (r < OUT_MIN) begin
            res = {1'b1, OUT_MIN[OUT_BITWIDTH-1:0]};
        end else begin
            res = {1'b0, r[OUT_BITWIDTH-1:0]};
        end
        return res;
    endfunction

    assign in_ext_s  = {{(ACC_BITWIDTH-IN_BITWIDTH){bus.IN_DATA[IN_BITWIDTH-1]}}, bus.IN_DATA};
    assign last_in_s = bus.IN_VALID && (count_r == (len_r - LEN_BITWIDTH'(1)));

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.START) begin
                    state_s = (bus.LEN == {LEN_BITWIDTH{1'b0}}) ? ST_ROUND : ST_ACCUM;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (last_in_s) begin
                    state_s = ST_ROUND;
                end else begin
                    state_s = ST_ACCUM;
                end
            end
            ST_ROUND: state_s = ST_HOLD;
            ST_HOLD: begin
                if (out_valid_r && bus.OUT_READY) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Accumulator, count and latched length.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_r   <= {ACC_BITWIDTH{1'b0}};
            count_r <= {LEN_BITWIDTH{1'b0}};
            len_r   <= {LEN_BITWIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.START) begin
                        acc_r   <= {ACC_BITWIDTH{1'b0}};
                        count_r <= {LEN_BITWIDTH{1'b0}};
                        len_r   <= bus.LEN;
                    end
                end
                ST_ACCUM: begin
                    if (bus.IN_VALID) begin
                        acc_r   <= acc_r + in_ext_s;
                        count_r <= count_r + LEN_BITWIDTH'(1);
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    // Output next values. Data and SAT persist after the handshake until the next ROUND.
    always_comb begin
        out_valid_s = out_valid_r;
        out_data_s  = out_data_r;
        sat_s       = sat_r;
        busy_s      = (state_s != ST_IDLE);
        case (state_r)
            ST_ROUND: begin
                out_valid_s         = 1'b1;
                {sat_s, out_data_s} = requant(acc_r);
            end
            ST_HOLD: begin
                if (bus.OUT_READY) begin
                    out_valid_s = 1'b0;
                end else begin
                    out_valid_s = out_valid_r;
                end
            end
            default: begin
                out_valid_s = out_valid_r;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {OUT_BITWIDTH{1'b0}};
            sat_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
            sat_r       <= sat_s;
            busy_r      <= busy_s;
        end
    end

    assign bus.OUT_VALID = out_valid_r;
    assign bus.OUT_DATA  = out_data_r;
    assign bus.SAT       = sat_r;
    assign bus.BUSY      = busy_r;
endmodule
